p23_muldiv_unit: RTL and testbench
==================================

# p23_muldiv_unit

Parametrised RV32M/RV64M execute unit for the kianv multicycle core; the successor to the combinational M-extension decoder. Decodes `funct3` of an M-extension instruction, runs the operation on a pipelined multiplier or an iterative restoring divider, and returns one result per request over a valid/ready/done handshake. Sits beside the ALU in the core datapath; the control FSM holds its execute state until `done_o`.

## Interface
Parameters:
- `XLEN`, 32, operand/result width (32 or 64)
- `MUL_STAGES`, 1, cycles spent in the MUL state (≥1); sets multiplier latency and permits retiming

Ports:
- `clk`  in  1  core clock, rising edge
- `resetn`  in  1  asynchronous, active-low reset
- `valid_i`  in  1  request present (was `mul_ext_valid`)
- `ready_o`  out  1  unit idle; request accepted on an edge where `valid_i & ready_o`
- `funct3`  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `rs1_i`, `rs2_i`  in  XLEN  operands, sampled only on accept
- `flush_i`  in  1  synchronous abort of an in-flight operation
- `done_o`  out  1  one-cycle pulse: `result_o` valid
- `result_o`  out  XLEN  result; held stable from `done_o` until the next accept
- `illegal_o`  out  1  qualified by `done_o`: op not supported in this build

## Operation
- States: IDLE, MUL, DIV_INIT, DIV_ITER, DIV_FIX, DONE.
- IDLE: `ready_o`=1. On accept: latch `funct3`/operands. funct3[2]=0 → MUL. funct3[2]=1 → DIV_INIT, or directly to DONE for the special cases below.
- MUL: 2·XLEN product of sign/zero-extended (XLEN+1-bit) operands.
  - rs1 is signed for MULH/MULHSU; rs2 is signed for MULH only.
  - MUL returns the low half; the others return the high half.
  - A counter stays in MUL for MUL_STAGES cycles, then → DONE.
- DIV_INIT (1 cycle): take magnitudes for signed ops; record quotient sign (sign1^sign2) and remainder sign (sign1).
- DIV_ITER: XLEN cycles of restoring shift-subtract; the counter counts XLEN-1 down to 0.
- DIV_FIX (1 cycle): apply sign correction; select quotient (DIV/DIVU) or remainder (REM/REMU).
- Special cases (decided at accept, no iteration):
  - rs2=0: DIV/DIVU → all ones; REM/REMU → rs1.
  - Signed overflow (rs1 = -2^(XLEN-1), rs2 = -1): DIV → rs1; REM → 0.
- DONE (1 cycle): `done_o`=1, `ready_o`=0, then → IDLE. `valid_i` is ignored outside IDLE.
- `flush_i` in any non-IDLE state → IDLE at the next edge. No `done_o` is generated; `result_o` keeps its prior value. `flush_i` in IDLE has no effect and does not block an accept in the same cycle.
- `illegal_o` is 0 for every legal completion.

## Timing
- Reset: state IDLE, `ready_o`=1, `done_o`=0, `illegal_o`=0, `result_o`=0, counters 0. Takes effect immediately, including mid-operation.
- Accept in cycle c → `done_o` high in cycle c+L:
  - MUL ops: L = MUL_STAGES+1
  - DIV ops: L = XLEN+3
  - Special cases: L = 1
- `ready_o` is low in cycles c+1 through c+L; the next accept is possible in cycle c+L+1.
- Registered outputs only. No combinational path from any input to `ready_o`/`done_o`.

## Configuration
- `P23_DIV_EN` defined: full M extension as above.
- Not defined (Zmmul build):
  - Divider datapath is removed.
  - Any funct3[2]=1 request goes to DONE with L=1, `illegal_o`=1, `result_o`=0.
  - MUL ops are unchanged.

## Test plan
- Reset: assert `resetn`=0 mid-DIV_ITER → `ready_o`=1, `done_o`=0, `result_o`=0 immediately. After release, MUL 7×6 returns 42 at L=MUL_STAGES+1.
- MULH family, XLEN=32, rs1=0xFFFFFFFF, rs2=2:
  - MUL → 0xFFFFFFFE
  - MULH → 0xFFFFFFFF
  - MULHSU → 0xFFFFFFFF
  - MULHU → 0x00000001
- DIV rs1=-7, rs2=2 → -3 (0xFFFFFFFD) at exactly c+35. REM same operands → -1. DIVU 100/7 → 14. REMU 100/7 → 2.
- Special cases, each with `done_o` at c+1:
  - DIV x/0 → 0xFFFFFFFF
  - REMU 5/0 → 5
  - DIV 0x80000000/-1 → 0x80000000
  - REM 0x80000000/-1 → 0
- `flush_i` pulsed in cycle c+10 of a DIV → no `done_o`, `ready_o`=1 at c+11. A new MUL 3×3 accepted at c+11 returns 9.
- Build without `P23_DIV_EN`: DIVU 10/2 → `done_o` at c+1 with `illegal_o`=1 and `result_o`=0. MUL 10×2 → 20 with `illegal_o`=0.

Source files
------------

// File: rtl/p23_muldiv_unit.sv
// p23_muldiv_unit
// RV32M/RV64M execute unit. Decodes funct3 of an M-extension instruction and
// runs it on a multiplier (MUL_STAGES cycles) or an iterative restoring
// divider (XLEN iterations). It returns one result per accepted request.
//
// Handshake: a request is accepted on a rising edge where valid_i & ready_o.
// ready_o is high only in IDLE. done_o pulses for one cycle in DONE. While
// done_o is high, result_o and illegal_o are valid. result_o then stays stable
// until the next accept. flush_i aborts any non-IDLE state without a done_o.
//
// Build option: define P23_DIV_EN for the full M extension. Without it
// (Zmmul build), the divider is removed. Any funct3[2]=1 op then completes in
// one cycle with illegal_o=1 and result_o=0.
//
// Ports:
//   clk, resetn         clock (rising edge), async active-low reset
//   valid_i / ready_o   request handshake
//   funct3              M-extension operation select
//   rs1_i, rs2_i        operands, sampled on accept
//   flush_i             synchronous abort of the in-flight op
//   done_o              one-cycle completion pulse
//   result_o            XLEN-bit result
//   illegal_o           op unsupported in this build (qualified by done_o)
//   dbg_state_o         current FSM state
module p23_muldiv_unit #(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            flush_i,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic            illegal_o,
  output logic [2:0]      dbg_state_o
);

  localparam int CW = $clog2(XLEN + MUL_STAGES) + 1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_MUL      = 3'd1,
    S_DIV_INIT = 3'd2,
    S_DIV_ITER = 3'd3,
    S_DIV_FIX  = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [1:0]        r_f3;
  logic [XLEN-1:0]   r_a;
  logic [XLEN-1:0]   r_b;
  logic [CW-1:0]     r_cnt;
  logic [XLEN-1:0]   r_result;
  logic              r_illegal;

  logic              w_special;
  logic [XLEN-1:0]   w_spec_result;
  logic              w_spec_illegal;

  // Multiplier: sign-extend both operands to 2*XLEN; the low 2*XLEN bits of
  // the product are exact for every signedness combination.
  logic              w_sign1;
  logic              w_sign2;
  logic [2*XLEN-1:0] w_mul_a;
  logic [2*XLEN-1:0] w_mul_b;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_mul_res;

  assign w_sign1   = r_f3[0] ^ r_f3[1];      // MULH, MULHSU
  assign w_sign2   = (r_f3 == 2'b01);        // MULH only
  assign w_mul_a   = {{XLEN{w_sign1 & r_a[XLEN-1]}}, r_a};
  assign w_mul_b   = {{XLEN{w_sign2 & r_b[XLEN-1]}}, r_b};
  assign w_prod    = w_mul_a * w_mul_b;
  assign w_mul_res = (r_f3 == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

`ifdef P23_DIV_EN
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_dvs;
  logic            r_q_neg;
  logic            r_r_neg;
  logic            w_rs2_zero;
  logic            w_ovf;
  logic            w_div_signed;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;
  logic [XLEN:0]   w_shift;
  logic [XLEN:0]   w_diff;
  logic [XLEN-1:0] w_div_res;

  // Special cases are decided on the live inputs at accept time.
  assign w_rs2_zero     = (rs2_i == '0);
  assign w_ovf          = ~funct3[0] & (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) & (&rs2_i);
  assign w_special      = funct3[2] & (w_rs2_zero | w_ovf);
  assign w_spec_illegal = 1'b0;
  always_comb begin
    w_spec_result = '0;
    if (w_rs2_zero) w_spec_result = funct3[1] ? rs1_i : '1;
    else            w_spec_result = funct3[1] ? '0 : rs1_i;
  end

  assign w_div_signed = ~r_f3[0];            // DIV, REM
  assign w_a_neg      = w_div_signed & r_a[XLEN-1];
  assign w_b_neg      = w_div_signed & r_b[XLEN-1];
  assign w_a_mag      = w_a_neg ? -r_a : r_a;
  assign w_b_mag      = w_b_neg ? -r_b : r_b;

  // One restoring step: shift the next dividend bit into the partial
  // remainder; keep the difference when it does not go negative.
  assign w_shift   = {r_rem, r_quo[XLEN-1]};
  assign w_diff    = w_shift - {1'b0, r_dvs};
  assign w_div_res = r_f3[1] ? (r_r_neg ? -r_rem : r_rem)
                             : (r_q_neg ? -r_quo : r_quo);
`else
  assign w_special      = funct3[2];
  assign w_spec_result  = '0;
  assign w_spec_illegal = 1'b1;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (valid_i) begin
          if (!funct3[2])     w_next = S_MUL;
          else if (w_special) w_next = S_DONE;
          else                w_next = S_DIV_INIT;
        end
      end
      S_MUL:      if (r_cnt == '0) w_next = S_DONE;
      S_DIV_INIT: w_next = S_DIV_ITER;
      S_DIV_ITER: if (r_cnt == '0) w_next = S_DIV_FIX;
      S_DIV_FIX:  w_next = S_DONE;
      S_DONE:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
    if (flush_i && (r_state != S_IDLE)) w_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_f3      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_cnt     <= '0;
      r_result  <= '0;
      r_illegal <= 1'b0;
`ifdef P23_DIV_EN
      r_rem     <= '0;
      r_quo     <= '0;
      r_dvs     <= '0;
      r_q_neg   <= 1'b0;
      r_r_neg   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (valid_i) begin
            r_f3  <= funct3[1:0];
            r_a   <= rs1_i;
            r_b   <= rs2_i;
            r_cnt <= CW'(MUL_STAGES - 1);
            if (w_special) begin
              r_result  <= w_spec_result;
              r_illegal <= w_spec_illegal;
            end
          end
        end
        S_MUL: begin
          if (flush_i) r_cnt <= '0;
          else if (r_cnt == '0) begin
            r_result  <= w_mul_res;
            r_illegal <= 1'b0;
          end else r_cnt <= r_cnt - 1'b1;
        end
`ifdef P23_DIV_EN
        S_DIV_INIT: begin
          r_rem   <= '0;
          r_quo   <= w_a_mag;
          r_dvs   <= w_b_mag;
          r_q_neg <= w_a_neg ^ w_b_neg;
          r_r_neg <= w_a_neg;
          r_cnt   <= CW'(XLEN - 1);
        end
        S_DIV_ITER: begin
          if (flush_i) r_cnt <= '0;
          else begin
            r_rem <= w_diff[XLEN] ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];
            r_quo <= {r_quo[XLEN-2:0], ~w_diff[XLEN]};
            if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DIV_FIX: begin
          if (!flush_i) begin
            r_result  <= w_div_res;
            r_illegal <= 1'b0;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign ready_o     = (r_state == S_IDLE);
  assign done_o      = (r_state == S_DONE);
  assign result_o    = r_result;
  assign illegal_o   = r_illegal;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_p23_muldiv_unit.sv
// Directed bench for p23_muldiv_unit (XLEN=32, MUL_STAGES=1). The divide
// expectations follow the build option P23_DIV_EN.
module tb_p23_muldiv_unit;
  localparam int XLEN  = 32;
  localparam int MS    = 1;
  localparam int L_MUL = MS + 1;
  localparam int L_DIV = XLEN + 3;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic            valid_i = 1'b0;
  logic            flush_i = 1'b0;
  logic [2:0]      funct3 = 3'b000;
  logic [XLEN-1:0] rs1_i = '0;
  logic [XLEN-1:0] rs2_i = '0;
  logic            ready_o;
  logic            done_o;
  logic            illegal_o;
  logic [XLEN-1:0] result_o;
  logic [2:0]      dbg_state_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  p23_muldiv_unit #(.XLEN(XLEN), .MUL_STAGES(MS)) dut (
    .clk(clk), .resetn(resetn), .valid_i(valid_i), .ready_o(ready_o),
    .funct3(funct3), .rs1_i(rs1_i), .rs2_i(rs2_i), .flush_i(flush_i),
    .done_o(done_o), .result_o(result_o), .illegal_o(illegal_o),
    .dbg_state_o(dbg_state_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one request in the current (idle) cycle; returns in cycle c+1 with
  // operands scrambled so that late sampling would show up.
  task automatic issue(input logic [2:0] f, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    funct3  = f;
    rs1_i   = a;
    rs2_i   = b;
    valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    rs1_i   = $urandom();
    rs2_i   = $urandom();
  endtask

  // Returns the cycle offset from accept to done_o (100 on timeout).
  task automatic wait_done(output int lat);
    lat = 1;
    while (done_o !== 1'b1 && lat < 100) begin
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    int lat;
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ready_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done_o); end
    checks++; if (result_o !== '0) begin errors++; $display("FAIL reset_result got=%h exp=0", result_o); end
    checks++; if (illegal_o !== 1'b0) begin errors++; $display("FAIL reset_illegal got=%b exp=0", illegal_o); end
    step(); step();
    resetn = 1'b1;
    step();
    issue(F_MUL, 32'd5, 32'd5);
    wait_done(lat);
    step();
`ifdef P23_DIV_EN
    issue(F_DIV, 32'd1000, 32'd3);
    repeat (5) step();
`else
    issue(F_MUL, 32'd9, 32'd9);
`endif
    #2 resetn = 1'b0;
    #1;
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL midop_reset_ready got=%b exp=1", ready_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL midop_reset_done got=%b exp=0", done_o); end
    checks++; if (result_o !== '0) begin errors++; $display("FAIL midop_reset_result got=%h exp=0", result_o); end
    checks++; if (dbg_state_o !== 3'd0) begin errors++; $display("FAIL midop_reset_state got=%0d exp=0", dbg_state_o); end
    step();
    resetn = 1'b1;
    step();
    issue(F_MUL, 32'd7, 32'd6);
    wait_done(lat);
    checks++; if (lat != L_MUL) begin errors++; $display("FAIL mul7x6_latency got=%0d exp=%0d", lat, L_MUL); end
    checks++; if (result_o !== 32'd42) begin errors++; $display("FAIL mul7x6_result got=%h exp=%h", result_o, 32'd42); end
    step();
  endtask

  task automatic test_mul_family();
    logic [2:0]      f[4];
    logic [XLEN-1:0] e[4];
    int lat;
    f[0] = F_MUL;    e[0] = 32'hFFFFFFFE;
    f[1] = F_MULH;   e[1] = 32'hFFFFFFFF;
    f[2] = F_MULHSU; e[2] = 32'hFFFFFFFF;
    f[3] = F_MULHU;  e[3] = 32'h00000001;
    for (int i = 0; i < 4; i++) begin
      issue(f[i], 32'hFFFFFFFF, 32'd2);
      checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL mul%0d_busy got=%b exp=0", i, ready_o); end
      wait_done(lat);
      checks++; if (lat != L_MUL) begin errors++; $display("FAIL mul%0d_latency got=%0d exp=%0d", i, lat, L_MUL); end
      checks++; if (result_o !== e[i]) begin errors++; $display("FAIL mul%0d_result got=%h exp=%h", i, result_o, e[i]); end
      checks++; if (illegal_o !== 1'b0) begin errors++; $display("FAIL mul%0d_illegal got=%b exp=0", i, illegal_o); end
      step();
    end
  endtask

`ifdef P23_DIV_EN
  task automatic test_div();
    logic [2:0]      f[4];
    logic [XLEN-1:0] a[4];
    logic [XLEN-1:0] b[4];
    logic [XLEN-1:0] e[4];
    int lat;
    f[0] = F_DIV;  a[0] = 32'hFFFFFFF9; b[0] = 32'd2; e[0] = 32'hFFFFFFFD;
    f[1] = F_REM;  a[1] = 32'hFFFFFFF9; b[1] = 32'd2; e[1] = 32'hFFFFFFFF;
    f[2] = F_DIVU; a[2] = 32'd100;      b[2] = 32'd7; e[2] = 32'd14;
    f[3] = F_REMU; a[3] = 32'd100;      b[3] = 32'd7; e[3] = 32'd2;
    for (int i = 0; i < 4; i++) begin
      issue(f[i], a[i], b[i]);
      wait_done(lat);
      checks++; if (lat != L_DIV) begin errors++; $display("FAIL div%0d_latency got=%0d exp=%0d", i, lat, L_DIV); end
      checks++; if (result_o !== e[i]) begin errors++; $display("FAIL div%0d_result got=%h exp=%h", i, result_o, e[i]); end
      checks++; if (illegal_o !== 1'b0) begin errors++; $display("FAIL div%0d_illegal got=%b exp=0", i, illegal_o); end
      step();
    end
  endtask

  task automatic test_special();
    logic [2:0]      f[4];
    logic [XLEN-1:0] a[4];
    logic [XLEN-1:0] b[4];
    logic [XLEN-1:0] e[4];
    int lat;
    f[0] = F_DIV;  a[0] = 32'd1234;      b[0] = 32'd0;        e[0] = 32'hFFFFFFFF;
    f[1] = F_REMU; a[1] = 32'd5;         b[1] = 32'd0;        e[1] = 32'd5;
    f[2] = F_DIV;  a[2] = 32'h80000000;  b[2] = 32'hFFFFFFFF; e[2] = 32'h80000000;
    f[3] = F_REM;  a[3] = 32'h80000000;  b[3] = 32'hFFFFFFFF; e[3] = 32'd0;
    for (int i = 0; i < 4; i++) begin
      issue(f[i], a[i], b[i]);
      wait_done(lat);
      checks++; if (lat != 1) begin errors++; $display("FAIL spec%0d_latency got=%0d exp=1", i, lat); end
      checks++; if (result_o !== e[i]) begin errors++; $display("FAIL spec%0d_result got=%h exp=%h", i, result_o, e[i]); end
      checks++; if (illegal_o !== 1'b0) begin errors++; $display("FAIL spec%0d_illegal got=%b exp=0", i, illegal_o); end
      step();
    end
  endtask
`else
  task automatic test_zmmul();
    int lat;
    issue(F_DIVU, 32'd10, 32'd2);
    wait_done(lat);
    checks++; if (lat != 1) begin errors++; $display("FAIL zmmul_divu_latency got=%0d exp=1", lat); end
    checks++; if (illegal_o !== 1'b1) begin errors++; $display("FAIL zmmul_divu_illegal got=%b exp=1", illegal_o); end
    checks++; if (result_o !== '0) begin errors++; $display("FAIL zmmul_divu_result got=%h exp=0", result_o); end
    step();
    issue(F_REM, 32'd7, 32'd0);
    wait_done(lat);
    checks++; if (illegal_o !== 1'b1) begin errors++; $display("FAIL zmmul_rem_illegal got=%b exp=1", illegal_o); end
    step();
    issue(F_MUL, 32'd10, 32'd2);
    wait_done(lat);
    checks++; if (lat != L_MUL) begin errors++; $display("FAIL zmmul_mul_latency got=%0d exp=%0d", lat, L_MUL); end
    checks++; if (result_o !== 32'd20) begin errors++; $display("FAIL zmmul_mul_result got=%h exp=%h", result_o, 32'd20); end
    checks++; if (illegal_o !== 1'b0) begin errors++; $display("FAIL zmmul_mul_illegal got=%b exp=0", illegal_o); end
    step();
  endtask
`endif

  task automatic test_flush();
    int lat;
    int flush_at;
    logic seen;
    logic [XLEN-1:0] prior;
    prior = result_o;
    seen = 1'b0;
`ifdef P23_DIV_EN
    flush_at = 10;
    issue(F_DIV, 32'd1000, 32'd3);
`else
    flush_at = 1;
    issue(F_MUL, 32'd1000, 32'd3);
`endif
    for (int k = 1; k < flush_at; k++) begin
      if (done_o === 1'b1) seen = 1'b1;
      step();
    end
    if (done_o === 1'b1) seen = 1'b1;
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_early_done got=%b exp=0", seen); end
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL flush_ready got=%b exp=1", ready_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL flush_done got=%b exp=0", done_o); end
    checks++; if (result_o !== prior) begin errors++; $display("FAIL flush_result_kept got=%h exp=%h", result_o, prior); end
    issue(F_MUL, 32'd3, 32'd3);
    wait_done(lat);
    checks++; if (lat != L_MUL) begin errors++; $display("FAIL after_flush_latency got=%0d exp=%0d", lat, L_MUL); end
    checks++; if (result_o !== 32'd9) begin errors++; $display("FAIL after_flush_result got=%h exp=%h", result_o, 32'd9); end
    step();
  endtask

  task automatic test_back_to_back();
    int lat;
    issue(F_MULHU, 32'h80000000, 32'h00000004);
    wait_done(lat);
    checks++; if (result_o !== 32'd2) begin errors++; $display("FAIL b2b_first_result got=%h exp=%h", result_o, 32'd2); end
    step();
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready_after_done got=%b exp=1", ready_o); end
    step(); step();
    checks++; if (result_o !== 32'd2) begin errors++; $display("FAIL b2b_result_hold got=%h exp=%h", result_o, 32'd2); end
    issue(F_MUL, 32'hFFFFFFFD, 32'd7);
    wait_done(lat);
    checks++; if (result_o !== 32'hFFFFFFEB) begin errors++; $display("FAIL b2b_second_result got=%h exp=%h", result_o, 32'hFFFFFFEB); end
    step();
  endtask

  initial begin
    #1;
    test_reset();
    test_mul_family();
`ifdef P23_DIV_EN
    test_div();
    test_special();
`else
    test_zmmul();
`endif
    test_flush();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
